// File: rtl/dp_patgen_if.sv
// Stuffer-facing FIFO port of the DisplayPort test-pattern source.
// master = pattern generator, slave = stuffer.
interface dp_patgen_if;
  logic        fiforden;
  logic        fifoempty;
  logic [47:0] fifodo;
  logic        sof;

  modport master (
    input  fiforden,
    output fifoempty,
    output fifodo,
    output sof
  );

  modport slave (
    output fiforden,
    input  fifoempty,
    input  fifodo,
    input  sof
  );
endinterface

// File: rtl/dp_patgen.sv
// Test-pattern pixel source, two pixels per word, FWFT output FIFO.
// Optional DP_PATGEN_CRC_EN adds a per-frame CRC-16-CCITT of popped words.
module dp_patgen #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [1:0]  patsel,
  input  logic [15:0] hactive,
  input  logic [15:0] vactive,
  input  logic [15:0] barw,
  input  logic [23:0] colour,
`ifdef DP_PATGEN_CRC_EN
  output logic [15:0] frame_crc,
  output logic        frame_crc_valid,
`endif
  dp_patgen_if.master fifo
);

`ifdef DP_PATGEN_CRC_EN
  localparam int EW = 50;
`else
  localparam int EW = 49;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head, entry;
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          empty, full, wr, pop;

  logic [15:0] x, y, bcnt;
  logic [2:0]  bdec;

  logic [1:0]  c_pat;
  logic [15:0] c_hact, c_vact, c_barw;
  logic [23:0] c_col;

  logic [1:0]  e_pat;
  logic [15:0] e_hact, e_vact, e_barw;
  logic [23:0] e_col;
  logic        first, eol, eof;
  logic [15:0] x1;
  logic [15:0] cnt_a, cnt_b;
  logic [2:0]  dec_a, dec_b;
  logic [23:0] p0, p1;

  function automatic logic [18:0] bar_step(
    input logic [15:0] c,
    input logic [2:0]  d,
    input logic [15:0] w
  );
    logic [15:0] n;
    n = c + 16'd1;
    if (n == w) return {16'd0, d + 3'd1};
    return {n, d};
  endfunction

  function automatic logic [23:0] pix(
    input logic [1:0]  p,
    input logic [7:0]  px,
    input logic        py5,
    input logic [2:0]  idx,
    input logic [23:0] col
  );
    logic [23:0] r;
    unique case (p)
      2'd0: r = col;
      2'd1: r = {px, px, px};
      2'd2: r = {{8{idx[2]}}, {8{idx[1]}},
                 {8{idx[0]}}};
      default:
        r = (px[5] ^ py5) ? 24'hFFFFFF : 24'h0;
    endcase
    return r;
  endfunction

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign wr    = en && !full;
  assign pop   = fifo.fiforden && !empty;
  assign head  = mem[rp];

  assign fifo.fifoempty = empty;
  assign fifo.fifodo    = empty ? 48'd0 : head[47:0];
  assign fifo.sof       = !empty && head[48];

  // First word of a frame uses live config; the rest use the latch.
  always_comb begin
    first  = (x == 16'd0) && (y == 16'd0);
    e_pat  = first ? patsel  : c_pat;
    e_hact = first ? hactive : c_hact;
    e_vact = first ? vactive : c_vact;
    e_barw = first ? barw    : c_barw;
    e_col  = first ? colour  : c_col;
    x1     = x + 16'd1;
    eol    = (x + 16'd2 == e_hact);
    eof    = eol && (y + 16'd1 == e_vact);
    {cnt_a, dec_a} = bar_step(bcnt, bdec, e_barw);
    {cnt_b, dec_b} = bar_step(cnt_a, dec_a, e_barw);
    p0 = pix(e_pat, x[7:0], y[5], ~bdec, e_col);
    p1 = pix(e_pat, x1[7:0], y[5], ~dec_a, e_col);
`ifdef DP_PATGEN_CRC_EN
    entry = {eof, first, p1, p0};
`else
    entry = {first, p1, p0};
`endif
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= entry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      wp     <= '0;
      rp     <= '0;
      x      <= '0;
      y      <= '0;
      bcnt   <= '0;
      bdec   <= '0;
      c_pat  <= '0;
      c_hact <= '0;
      c_vact <= '0;
      c_barw <= '0;
      c_col  <= '0;
    end else if (!en) begin
      cnt  <= '0;
      wp   <= '0;
      rp   <= '0;
      x    <= '0;
      y    <= '0;
      bcnt <= '0;
      bdec <= '0;
    end else begin
      if (wr) begin
        wp <= wp + 1'b1;
        if (first) begin
          c_pat  <= patsel;
          c_hact <= hactive;
          c_vact <= vactive;
          c_barw <= barw;
          c_col  <= colour;
        end
        if (eol) begin
          x    <= '0;
          bcnt <= '0;
          bdec <= '0;
          y    <= eof ? 16'd0 : y + 16'd1;
        end else begin
          x    <= x + 16'd2;
          bcnt <= cnt_b;
          bdec <= dec_b;
        end
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end

`ifdef DP_PATGEN_CRC_EN
  logic [15:0] crc, crc_nx;

  function automatic logic [15:0] crc48(
    input logic [15:0] c,
    input logic [47:0] d
  );
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 47; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0);
    end
    return r;
  endfunction

  assign crc_nx = crc48(head[48] ? 16'hFFFF : crc,
                        head[47:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc             <= '0;
      frame_crc       <= '0;
      frame_crc_valid <= 1'b0;
    end else begin
      frame_crc_valid <= pop && head[49];
      if (pop) crc <= crc_nx;
      if (pop && head[49]) frame_crc <= crc_nx;
    end
  end
`endif

endmodule

// File: tb/tb_dp_patgen.sv
// Scoreboard bench for dp_patgen: model stream queued per segment,
// negedge monitor checks every head word and pop.
module tb_dp_patgen;
  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [1:0]  patsel;
  logic [15:0] hactive, vactive, barw;
  logic [23:0] colour;
  logic        rden;
`ifdef DP_PATGEN_CRC_EN
  logic [15:0] frame_crc;
  logic        frame_crc_valid;
  logic [15:0] crc_m = 16'hFFFF;
  logic [15:0] crc_exp = 16'h0;
  logic        crc_pend = 1'b0;
`endif

  dp_patgen_if pif ();
  assign pif.fiforden = rden;

  dp_patgen #(.DEPTH(4), .AW(2)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .en      (en),
    .patsel  (patsel),
    .hactive (hactive),
    .vactive (vactive),
    .barw    (barw),
    .colour  (colour),
`ifdef DP_PATGEN_CRC_EN
    .frame_crc       (frame_crc),
    .frame_crc_valid (frame_crc_valid),
`endif
    .fifo    (pif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int npop = 0;
  bit mon_on = 0;
  logic [49:0] q[$];
  logic [49:0] mon_e;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic bad(input string nm);
    n_chk++;
    $display("FAIL %s: got event, want none", nm);
  endtask

  function automatic logic [23:0] mpix(
    input int pat, input int px, input int py,
    input int bw, input logic [23:0] col);
    int i;
    logic [7:0] r, g, b;
    case (pat)
      0: return col;
      1: begin
        r = 8'(px % 256);
        return {r, r, r};
      end
      2: begin
        i = 7 - ((px / bw) % 8);
        r = ((i / 4) % 2) != 0 ? 8'hFF : 8'h00;
        g = ((i / 2) % 2) != 0 ? 8'hFF : 8'h00;
        b = (i % 2) != 0 ? 8'hFF : 8'h00;
        return {r, g, b};
      end
      default: begin
        if ((((px / 32) % 2) ^ ((py / 32) % 2)) != 0)
          return 24'hFFFFFF;
        return 24'h000000;
      end
    endcase
  endfunction

`ifdef DP_PATGEN_CRC_EN
  function automatic logic [15:0] mcrc(
    input logic [15:0] c, input logic [47:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 47; i >= 0; i--) begin
      if (r[15] != d[i]) r = (r << 1) ^ 16'h1021;
      else r = r << 1;
    end
    return r;
  endfunction
`endif

  task automatic fill(input int pat, input int h,
                      input int v, input int bw,
                      input logic [23:0] col,
                      input int need);
    logic sf, ef;
    while (q.size() < need) begin
      for (int yy = 0; yy < v; yy++)
        for (int xx = 0; xx < h; xx += 2) begin
          sf = (xx == 0) && (yy == 0);
          ef = (xx + 2 == h) && (yy + 1 == v);
          q.push_back({ef, sf,
            mpix(pat, xx + 1, yy, bw, col),
            mpix(pat, xx, yy, bw, col)});
        end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
`ifdef DP_PATGEN_CRC_EN
      if (frame_crc_valid) begin
        if (!crc_pend) bad("crc_valid_spurious");
        else chk("frame_crc", 64'(frame_crc),
                 64'(crc_exp));
        crc_pend = 0;
      end else if (crc_pend) begin
        chk("crc_valid", 64'(frame_crc_valid), 64'd1);
        crc_pend = 0;
      end
`endif
      if (!pif.fifoempty) begin
        if (q.size() == 0) bad("queue_underrun");
        else begin
          mon_e = q[0];
          chk("head_word", {15'd0, pif.sof, pif.fifodo},
              {15'd0, mon_e[48:0]});
          if (rden) begin
            void'(q.pop_front());
            npop++;
`ifdef DP_PATGEN_CRC_EN
            if (mon_e[48]) crc_m = 16'hFFFF;
            crc_m = mcrc(crc_m, mon_e[47:0]);
            if (mon_e[49]) begin
              crc_pend = 1;
              crc_exp  = crc_m;
            end
`endif
          end
        end
      end
    end
  end

  // Config only changes while en=0 and the FIFO is flushed.
  task automatic seg(input int pat, input int h,
                     input int v, input int bw,
                     input logic [23:0] col,
                     input int ncyc, input int mode);
    patsel  = 2'(pat);
    hactive = 16'(h);
    vactive = 16'(v);
    barw    = 16'(bw);
    colour  = col;
    q.delete();
    fill(pat, h, v, bw, col, ncyc + 8);
    npop = 0;
    en = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      case (mode)
        0: rden = ($urandom % 10) < 7;
        1: rden = 1'b1;
        default: rden = (c >= 20) && (c % 2 == 0);
      endcase
      @(posedge clk);
      #1;
    end
    en = 1'b0;
    rden = 1'($urandom % 2);
    @(posedge clk);
    #1;
    chk("flush_empty", 64'(pif.fifoempty), 64'd1);
    chk("progress", 64'(npop > 0), 64'd1);
    rden = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    en = 1'b0;
    rden = 1'b0;
    patsel = '0;
    hactive = '0;
    vactive = '0;
    barw = '0;
    colour = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 64'(pif.fifoempty), 64'd1);
    chk("rst_fifodo", 64'(pif.fifodo), 64'd0);
    chk("rst_sof", 64'(pif.sof), 64'd0);
`ifdef DP_PATGEN_CRC_EN
    chk("rst_crc", 64'(frame_crc), 64'd0);
    chk("rst_crc_valid", 64'(frame_crc_valid), 64'd0);
`endif
    resetn = 1'b1;
    mon_on = 1;
    @(posedge clk);
    #1;

    seg(0, 4, 2, 1, 24'h123456, 12, 1);
    seg(1, 512, 1, 1, 24'h0, 300, 1);
    seg(2, 16, 1, 3, 24'h0, 40, 1);
    seg(2, 40, 2, 3, 24'h0, 60, 0);
    seg(1, 16, 2, 1, 24'h0, 60, 2);
    seg(3, 64, 2, 1, 24'h0, 80, 0);
    seg(3, 4, 40, 1, 24'h0, 200, 1);
    seg(1, 16, 2, 1, 24'h0, 4, 1);
    seg(2, 16, 2, 2, 24'h0, 30, 0);

    // Asynchronous reset mid-frame, away from any clock edge.
    patsel = 2'd1;
    hactive = 16'd16;
    vactive = 16'd2;
    barw = 16'd1;
    q.delete();
    fill(1, 16, 2, 1, 24'h0, 20);
    en = 1'b1;
    rden = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    resetn = 1'b0;
    mon_on = 0;
`ifdef DP_PATGEN_CRC_EN
    crc_pend = 0;
`endif
    #1;
    chk("async_rst_empty", 64'(pif.fifoempty), 64'd1);
    chk("async_rst_sof", 64'(pif.sof), 64'd0);
    chk("async_rst_do", 64'(pif.fifodo), 64'd0);
    en = 1'b0;
    rden = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    q.delete();
    mon_on = 1;
    @(posedge clk);
    #1;

    seg(0, 2, 1, 1, 24'h000000, 20, 1);
    seg(0, 6, 3, 1, 24'hA5C33C, 40, 0);

    for (int s = 0; s < 10; s++) begin
      seg($urandom_range(0, 3),
          2 * $urandom_range(1, 20),
          $urandom_range(1, 4),
          $urandom_range(1, 6),
          24'($urandom),
          $urandom_range(40, 120), 0);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
